sha256_iter: RTL and testbench

SHA256_ITER -- requirements
Module: sha256_iter

---
 rtl/sha256_pkg.sv | 67 ++++++
 rtl/sha256_round.sv | 42 ++++
 rtl/sha256_iter.sv | 103 ++++++++++
 tb/tb_sha256_iter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the FIPS 180-4 logical functions
// used by the iterative compressor and its round datapath.
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_t;

  localparam int unsigned ROUNDS = 64;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: working variables a..h plus K_t and W_t
// in, updated a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
  input  logic [31:0] e_in,
  input  logic [31:0] f_in,
  input  logic [31:0] g_in,
  input  logic [31:0] h_in,
  input  logic [31:0] k_t,
  input  logic [31:0] w_t,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic [31:0] e_out,
  output logic [31:0] f_out,
  output logic [31:0] g_out,
  output logic [31:0] h_out
);

  logic [31:0] t1;
  logic [31:0] t2;

  always_comb begin
    t1    = h_in + big_sigma1(e_in) + ch(e_in, f_in, g_in) + k_t + w_t;
    t2    = big_sigma0(a_in) + maj(a_in, b_in, c_in);
    a_out = t1 + t2;
    b_out = a_in;
    c_out = b_in;
    d_out = c_in;
    e_out = d_in + t1;
    f_out = e_in;
    g_out = f_in;
    h_out = g_in;
  end

endmodule

// File: rtl/sha256_iter.sv
// Iterative SHA-256 block compressor: one round per clock, 66-cycle
// start-to-done latency, registered chaining value on hash.
module sha256_iter
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         first,
  input  logic [0:511] block,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [0:255] hash
);

  state_t      state;
  state_t      state_nx;
  logic [5:0]  rnd;
  logic        accept;
  logic        first_q;
  logic [31:0] v   [8];
  logic [31:0] nx  [8];
  logic [31:0] w   [16];
  logic [31:0] w_new;

  assign ready  = (state == IDLE) && !reset;
  assign busy   = (state != IDLE);
  assign accept = start && ready;
  assign w_new  = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ROUND;
      ROUND:   if (rnd == 6'(ROUNDS - 1)) state_nx = FINAL;
      FINAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rnd  <= '0;
      done <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) hash[32*i +: 32] <= IV[i];
    end else begin
      done <= (state == FINAL);
      case (state)
        IDLE:  if (accept) rnd <= '0;
        ROUND: rnd <= rnd + 6'd1;
        FINAL: begin
          // Only the first flag is kept; a first=1 block re-reads IV here
          // instead of storing a separate 256-bit chain copy.
          for (int unsigned i = 0; i < 8; i++)
            hash[32*i +: 32] <= (first_q ? IV[i] : hash[32*i +: 32]) + v[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      first_q <= first;
      for (int unsigned i = 0; i < 8; i++)
        v[i] <= first ? IV[i] : hash[32*i +: 32];
      for (int unsigned i = 0; i < 16; i++)
        w[i] <= block[32*i +: 32];
    end else if (state == ROUND) begin
      for (int unsigned i = 0; i < 8; i++) v[i] <= nx[i];
      for (int unsigned i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= w_new;
    end
  end

  sha256_round u_round (
    .a_in  (v[0]),
    .b_in  (v[1]),
    .c_in  (v[2]),
    .d_in  (v[3]),
    .e_in  (v[4]),
    .f_in  (v[5]),
    .g_in  (v[6]),
    .h_in  (v[7]),
    .k_t   (K[rnd]),
    .w_t   (w[0]),
    .a_out (nx[0]),
    .b_out (nx[1]),
    .c_out (nx[2]),
    .d_out (nx[3]),
    .e_out (nx[4]),
    .f_out (nx[5]),
    .g_out (nx[6]),
    .h_out (nx[7])
  );

endmodule

// File: tb/tb_sha256_iter.sv
// Self-checking bench for sha256_iter: known-answer digests, timing/handshake
// checks and random chained blocks against a plain FIPS 180-4 model.
module tb_sha256_iter;
  import sha256_pkg::K;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         first;
  logic [0:511] block;
  logic         ready;
  logic         busy;
  logic         done;
  logic [0:255] hash;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [255:0] model_h;

  localparam logic [255:0] IV_H =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  sha256_iter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .first (first),
    .block (block),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .hash  (hash)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] chain,
                                                input logic [511:0] blk);
    logic [31:0] wx [64];
    logic [31:0] hh [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) wx[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      wx[t] = (rr(wx[t-2], 17) ^ rr(wx[t-2], 19) ^ (wx[t-2] >> 10)) + wx[t-7]
            + (rr(wx[t-15], 7) ^ rr(wx[t-15], 18) ^ (wx[t-15] >> 3)) + wx[t-16];
    for (int i = 0; i < 8; i++) hh[i] = chain[255 - 32*i -: 32];
    a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3];
    e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + wx[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hh[0] + a, hh[1] + b, hh[2] + c, hh[3] + d,
            hh[4] + e, hh[5] + f, hh[6] + g, hh[7] + h};
  endfunction

  // Starts one block in the current cycle and returns in its done cycle, so
  // consecutive calls issue back-to-back starts.
  task automatic run_block(input string tag, input logic f, input logic [0:511] blk,
                           input bit disturb, output logic [255:0] got);
    int unsigned n;
    logic [255:0] held;
    held = model_h;
    check({tag, "_ready_at_start"}, ready, 1);
    first = f;
    block = blk;
    start = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      start = 1'b0;
      if (n == 1) check({tag, "_busy"}, busy, 1);
      if (disturb && n >= 5 && n <= 20) begin
        start = 1'($urandom_range(0, 1));
        first = 1'($urandom_range(0, 1));
        for (int i = 0; i < 16; i++) block[32*i +: 32] = $urandom();
      end
      if (n == 30) check({tag, "_hash_held"}, hash, held);
    end while (!done && n < 100);
    start = 1'b0;
    check({tag, "_latency"}, n, 66);
    check({tag, "_ready_done"}, ready, 1);
    check({tag, "_busy_done"}, busy, 0);
    got = hash;
  endtask

  initial begin
    logic [0:511]  m_abc, m_empty, m_two1, m_two2, rblk;
    logic [255:0]  got, exp;
    logic          rf;
    bit            seen_done;

    m_abc   = {32'h61626380, 448'h0, 32'h00000018};
    m_empty = {32'h80000000, 480'h0};
    m_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
               32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
               32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
               32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    m_two2  = {480'h0, 32'h000001c0};

    reset = 1'b1; start = 1'b0; first = 1'b0; block = '0;
    repeat (3) tick();
    check("rst_hash", hash, IV_H);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", ready, 1);
    model_h = IV_H;

    // first=0 right after reset chains from the reset IV
    run_block("empty_first0", 1'b0, m_empty, 1'b0, got);
    check("empty_digest", got, D_EMPTY);
    model_h = D_EMPTY;

    run_block("abc_b2b", 1'b1, m_abc, 1'b0, got);
    check("abc_digest", got, D_ABC);
    model_h = D_ABC;

    exp = ref_compress(IV_H, m_two1);
    run_block("two_blk1", 1'b1, m_two1, 1'b0, got);
    check("two_blk1_model", got, exp);
    model_h = exp;
    run_block("two_blk2", 1'b0, m_two2, 1'b0, got);
    check("two_digest", got, D_TWO);
    model_h = D_TWO;

    run_block("abc_disturb", 1'b1, m_abc, 1'b1, got);
    check("abc_disturb_digest", got, D_ABC);
    model_h = D_ABC;

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom();
      rf  = 1'($urandom_range(0, 1));
      exp = ref_compress(rf ? IV_H : model_h, rblk);
      run_block($sformatf("rnd%0d", k), rf, rblk, 1'b0, got);
      check($sformatf("rnd%0d_digest", k), got, exp);
      model_h = exp;
    end

    // Abort a block at round 30 with reset.
    first = 1'b1; block = m_abc; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (30) tick();
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check("abort_hash", hash, IV_H);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ready_in_rst", ready, 0);
    reset = 1'b0;
    #1;
    check("abort_ready_release", ready, 1);
    model_h = IV_H;
    seen_done = 1'b0;
    repeat (80) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    run_block("abc_after_abort", 1'b1, m_abc, 1'b0, got);
    check("abc_after_abort_digest", got, D_ABC);
    model_h = D_ABC;

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; first = 1'b1; block = m_abc;
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    check("rst_prio_busy", busy, 0);
    check("rst_prio_hash", hash, IV_H);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
